// File: rtl/cmos_capture_ctrl_if.sv
// Capture FIFO write-side bundle: strobe and word out, full back.
// master = cmos_capture_ctrl, slave = FIFO write port.
interface cmos_capture_ctrl_if;
  logic        fifo_wrreq;
  logic [15:0] fifo_data;
  logic        fifo_full;

  modport master (
    output fifo_wrreq,
    output fifo_data,
    input  fifo_full
  );

  modport slave (
    input  fifo_wrreq,
    input  fifo_data,
    output fifo_full
  );
endinterface

// File: rtl/cmos_capture_ctrl.sv
// CMOS pixel stream to RGB565 capture FIFO sequencer, cmos_pclk domain.
// CAPTURE_TEST_PATTERN_EN: replace camera words with 8-band colour bars.
module cmos_capture_ctrl #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                       cmos_pclk,
  input  logic                       rst_133,
  input  logic                       cfg_done,
  input  logic                       capture_en,
  input  logic                       cmos_vsyn,
  input  logic                       cmos_href,
  input  logic [7:0]                 cmos_data,
  cmos_capture_ctrl_if.master        fifo,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic [9:0]                 line_cnt,
  output logic                       overflow,
  output logic                       line_err,
  output logic                       frame_err
);

  localparam logic [10:0] H_CNT     = 11'(H_PIXELS);
  localparam logic [9:0]  V_CNT     = 10'(V_LINES);
  localparam logic [15:0] SKIP_LAST = 16'(SKIP_FRAMES - 1);
  localparam bit          SKIP_NONE = (SKIP_FRAMES == 0);

  typedef enum logic [1:0] {
    S_WAIT_CFG,
    S_SKIP,
    S_WAIT_VS,
    S_ACTIVE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cfg_s1;
  logic        r_cfg_s2;
  logic        r_vs_r1;
  logic        r_vs_r2;
  logic        r_hr_r1;
  logic        r_hr_r2;
  logic [7:0]  r_dat_r1;

  logic [15:0] r_skip_cnt;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [10:0] r_pix_cnt;

  logic        w_vs_rise;
  logic        w_hr_fall;
  logic        w_active;
  logic [9:0]  w_line_inc;
  logic [10:0] w_pix_inc;
  logic        w_last_line;
  logic [15:0] w_word;

  logic        w_start;
  logic        w_done;
  logic        w_clear;
  logic        w_clr_sticky;
  logic        w_ferr_set;
  logic        w_skip_inc;
  logic        w_skip_clr;
  logic        w_drop;
  logic        w_bad_line;

  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      r_cfg_s1 <= 1'b0;
      r_cfg_s2 <= 1'b0;
      r_vs_r1  <= 1'b0;
      r_vs_r2  <= 1'b0;
      r_hr_r1  <= 1'b0;
      r_hr_r2  <= 1'b0;
      r_dat_r1 <= '0;
    end else begin
      r_cfg_s1 <= cfg_done;
      r_cfg_s2 <= r_cfg_s1;
      r_vs_r1  <= cmos_vsyn;
      r_vs_r2  <= r_vs_r1;
      r_hr_r1  <= cmos_href;
      r_hr_r2  <= r_hr_r1;
      r_dat_r1 <= cmos_data;
    end
  end

  assign w_vs_rise  = r_vs_r1 & ~r_vs_r2;
  assign w_hr_fall  = ~r_hr_r1 & r_hr_r2;
  assign w_active   = (r_state == S_ACTIVE);
  assign w_line_inc = (line_cnt == 10'h3FF) ?
                      line_cnt : line_cnt + 10'd1;
  assign w_pix_inc  = (r_pix_cnt == 11'h7FF) ?
                      r_pix_cnt : r_pix_cnt + 11'd1;
  assign w_last_line = w_active & w_hr_fall &
                       (w_line_inc == V_CNT);

  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      r_state <= S_WAIT_CFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_clear      = 1'b0;
    w_clr_sticky = 1'b0;
    w_ferr_set   = 1'b0;
    w_skip_inc   = 1'b0;
    w_skip_clr   = 1'b0;
    unique case (r_state)
      S_WAIT_CFG: begin
        w_skip_clr = 1'b1;
        if (r_cfg_s2) w_state_nxt = S_SKIP;
      end
      S_SKIP: begin
        if (SKIP_NONE) begin
          w_state_nxt = S_WAIT_VS;
        end else if (w_vs_rise) begin
          w_skip_inc = 1'b1;
          if (r_skip_cnt == SKIP_LAST)
            w_state_nxt = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        if (w_vs_rise && capture_en) begin
          w_state_nxt  = S_ACTIVE;
          w_start      = 1'b1;
          w_clear      = 1'b1;
          w_clr_sticky = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Early vsync: flag it and restart the frame in place
        if (w_vs_rise) begin
          w_ferr_set = 1'b1;
          w_clear    = 1'b1;
          if (capture_en) begin
            w_start      = 1'b1;
            w_clr_sticky = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_VS;
          end
        end else if (w_last_line) begin
          w_done      = 1'b1;
          w_state_nxt = S_WAIT_VS;
        end
      end
      default: w_state_nxt = S_WAIT_CFG;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      r_skip_cnt <= '0;
    end else if (w_skip_clr) begin
      r_skip_cnt <= '0;
    end else if (w_skip_inc) begin
      r_skip_cnt <= r_skip_cnt + 16'd1;
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [15:0] w_bar;

  always_comb begin
    w_bar = 16'h0000;
    unique case (r_pix_cnt[9:7])
      3'd0: w_bar = 16'hFFFF;
      3'd1: w_bar = 16'hFFE0;
      3'd2: w_bar = 16'h07FF;
      3'd3: w_bar = 16'h07E0;
      3'd4: w_bar = 16'hF81F;
      3'd5: w_bar = 16'hF800;
      3'd6: w_bar = 16'h001F;
      3'd7: w_bar = 16'h0000;
      default: w_bar = 16'h0000;
    endcase
  end

  assign w_word = w_bar;
`else
  assign w_word = {r_hi, r_dat_r1};
`endif

  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      r_phase         <= 1'b0;
      r_hi            <= '0;
      r_pix_cnt       <= '0;
      line_cnt        <= '0;
      fifo.fifo_wrreq <= 1'b0;
      fifo.fifo_data  <= '0;
      frame_start     <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      fifo.fifo_wrreq <= 1'b0;
      frame_start     <= w_start;
      frame_done      <= w_done;
      if (w_clear) begin
        r_phase   <= 1'b0;
        r_pix_cnt <= '0;
        line_cnt  <= '0;
      end else if (w_active) begin
        if (w_hr_fall) begin
          r_phase   <= 1'b0;
          r_pix_cnt <= '0;
          line_cnt  <= w_line_inc;
        end else if (r_hr_r1) begin
          if (!r_phase) begin
            r_hi    <= r_dat_r1;
            r_phase <= 1'b1;
          end else begin
            r_phase   <= 1'b0;
            r_pix_cnt <= w_pix_inc;
            if (!fifo.fifo_full) begin
              fifo.fifo_wrreq <= 1'b1;
              fifo.fifo_data  <= w_word;
            end
          end
        end
      end
    end
  end

  assign w_drop = w_active & ~w_clear & ~w_hr_fall &
                  r_hr_r1 & r_phase & fifo.fifo_full;
  assign w_bad_line = w_active & ~w_clear & w_hr_fall &
                      ((r_pix_cnt != H_CNT) | r_phase);

  always_ff @(posedge cmos_pclk or negedge rst_133) begin
    if (!rst_133) begin
      overflow  <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_clr_sticky) overflow <= 1'b0;
      else if (w_drop)  overflow <= 1'b1;
      if (w_clr_sticky)    line_err <= 1'b0;
      else if (w_bad_line) line_err <= 1'b1;
      if (w_ferr_set)        frame_err <= 1'b1;
      else if (w_clr_sticky) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Frame-table bench for cmos_capture_ctrl with a write-word scoreboard.
// Reduced frame geometry keeps the run short.
module tb_cmos_capture_ctrl;
`ifdef CAPTURE_TEST_PATTERN_EN
  localparam int H = 136;
`else
  localparam int H = 16;
`endif
  localparam int V    = 8;
  localparam int SKIP = 2;
  localparam int GAP  = 6;

  logic       cmos_pclk;
  logic       rst_133;
  logic       cfg_done;
  logic       capture_en;
  logic       cmos_vsyn;
  logic       cmos_href;
  logic [7:0] cmos_data;
  logic       frame_start;
  logic       frame_done;
  logic [9:0] line_cnt;
  logic       overflow;
  logic       line_err;
  logic       frame_err;

  cmos_capture_ctrl_if u_if();

  cmos_capture_ctrl #(
    .H_PIXELS    (H),
    .V_LINES     (V),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .cmos_pclk   (cmos_pclk),
    .rst_133     (rst_133),
    .cfg_done    (cfg_done),
    .capture_en  (capture_en),
    .cmos_vsyn   (cmos_vsyn),
    .cmos_href   (cmos_href),
    .cmos_data   (cmos_data),
    .fifo        (u_if),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_cnt    (line_cnt),
    .overflow    (overflow),
    .line_err    (line_err),
    .frame_err   (frame_err)
  );

  typedef struct {
    int nl;
    int cap;
    int drop;
    int badl;
    int badb;
    int fl;
    int fat;
    int flen;
    int es;
    int ed;
    int el;
    int elerr;
    int eovf;
    int eferr;
  } frame_t;

  int          n_vec;
  int          n_err;
  int          n_start;
  int          n_done;
  logic        prev_wr;
  logic [7:0]  bcnt;
  logic [15:0] q_exp[$];
  frame_t      tbl[11];
  frame_t      sk;

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [15:0] bar[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  initial begin
    cmos_pclk = 1'b0;
    forever #5 cmos_pclk = ~cmos_pclk;
  end

  function automatic frame_t mk(
    input int nl, input int cap, input int drop,
    input int badl, input int badb,
    input int fl, input int fat, input int flen,
    input int es, input int ed, input int el,
    input int elerr, input int eovf, input int eferr);
    frame_t f;
    f.nl = nl; f.cap = cap; f.drop = drop;
    f.badl = badl; f.badb = badb;
    f.fl = fl; f.fat = fat; f.flen = flen;
    f.es = es; f.ed = ed; f.el = el;
    f.elerr = elerr; f.eovf = eovf; f.eferr = eferr;
    return f;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [7:0] hi,
                                           input logic [7:0] lo,
                                           input int idx);
`ifdef CAPTURE_TEST_PATTERN_EN
    exp_word = bar[(idx >> 7) & 7];
    if (hi == lo && idx < 0) exp_word = 16'h0;
`else
    exp_word = {hi, lo};
    if (idx < 0) exp_word = 16'h0;
`endif
  endfunction

  task automatic tick();
    @(negedge cmos_pclk);
    if (u_if.fifo_wrreq) begin
      chk("wr_back_to_back", {31'b0, prev_wr}, 32'd0);
      n_vec++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got write 0x%0h want none",
                 u_if.fifo_data);
      end else begin
        n_vec--;
        chk("wr_data", {16'b0, u_if.fifo_data},
            {16'b0, q_exp.pop_front()});
      end
    end
    prev_wr = u_if.fifo_wrreq;
    if (frame_start) n_start++;
    if (frame_done)  n_done++;
  endtask

  task automatic drive_line(input int nb, input int f_at,
                            input int f_len, input bit cap);
    logic [7:0] hi;
    bit         dropped;
    hi = '0;
    for (int j = 0; j < nb + GAP; j++) begin
      tick();
      u_if.fifo_full = (j >= f_at) && (j < f_at + f_len);
      if (j < nb) begin
        cmos_href = 1'b1;
        cmos_data = bcnt;
        if (j % 2 == 0) begin
          hi = bcnt;
        end else if (cap) begin
          dropped = (j + 1 >= f_at) && (j + 1 < f_at + f_len);
          if (!dropped) q_exp.push_back(exp_word(hi, bcnt, j / 2));
        end
        bcnt++;
      end else begin
        cmos_href = 1'b0;
        cmos_data = '0;
      end
    end
    u_if.fifo_full = 1'b0;
  endtask

  task automatic drive_frame(input frame_t f);
    int s0;
    int d0;
    int nb;
    bit cap;
    s0   = n_start;
    d0   = n_done;
    bcnt = '0;
    cap  = (f.es != 0);
    tick();
    cmos_vsyn  = 1'b1;
    capture_en = (f.cap != 0);
    tick();
    chk("fs_early", {31'b0, frame_start}, 32'd0);
    tick();
    chk("fs_timing", {31'b0, frame_start}, f.es);
    tick();
    cmos_vsyn = 1'b0;
    repeat (3) tick();
    if (cap) chk("lc_cleared", {22'b0, line_cnt}, 32'd0);
    for (int l = 0; l < f.nl; l++) begin
      if (l == f.drop) capture_en = 1'b0;
      nb = (l == f.badl) ? f.badb : 2 * H;
      if (l == f.fl) drive_line(nb, f.fat, f.flen, cap);
      else           drive_line(nb, 0, 0, cap);
    end
    repeat (4) tick();
    chk("n_frame_start", n_start - s0, f.es);
    chk("n_frame_done", n_done - d0, f.ed);
    chk("line_cnt", {22'b0, line_cnt}, f.el);
    chk("line_err", {31'b0, line_err}, f.elerr);
    chk("overflow", {31'b0, overflow}, f.eovf);
    chk("frame_err", {31'b0, frame_err}, f.eferr);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wrreq", {31'b0, u_if.fifo_wrreq}, 32'd0);
    chk("rst_data", {16'b0, u_if.fifo_data}, 32'd0);
    chk("rst_fstart", {31'b0, frame_start}, 32'd0);
    chk("rst_fdone", {31'b0, frame_done}, 32'd0);
    chk("rst_line_cnt", {22'b0, line_cnt}, 32'd0);
    chk("rst_flags", {29'b0, overflow, line_err, frame_err}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_start = 0; n_done = 0;
    prev_wr = 1'b0; bcnt = '0;
    rst_133 = 1'b0; cfg_done = 1'b0; capture_en = 1'b0;
    cmos_vsyn = 1'b0; cmos_href = 1'b0; cmos_data = '0;
    u_if.fifo_full = 1'b0;

    sk      = mk(2, 1, -1, -1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = sk;
    tbl[1]  = sk;
    tbl[2]  = mk(V, 1, -1, -1, 0, -1, 0, 0, 1, 1, V, 0, 0, 0);
    tbl[3]  = mk(V, 1, -1, -1, 0, 3, 5, 10, 1, 1, V, 0, 1, 0);
    tbl[4]  = mk(V, 1, -1, 2, 2*H-2, -1, 0, 0, 1, 1, V, 1, 0, 0);
    tbl[5]  = mk(V, 1, -1, 5, 2*H-1, -1, 0, 0, 1, 1, V, 1, 0, 0);
    tbl[6]  = mk(3, 1, -1, -1, 0, -1, 0, 0, 1, 0, 3, 0, 0, 0);
    tbl[7]  = mk(V, 1, -1, -1, 0, -1, 0, 0, 1, 1, V, 0, 0, 1);
    tbl[8]  = mk(V, 1, 4, -1, 0, -1, 0, 0, 1, 1, V, 0, 0, 0);
    tbl[9]  = mk(V, 0, -1, -1, 0, -1, 0, 0, 0, 0, V, 0, 0, 0);
    tbl[10] = mk(V, 1, -1, -1, 0, -1, 0, 0, 1, 1, V, 0, 0, 0);

    repeat (3) tick();
    chk_reset_vals();
    rst_133 = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 5; i++) drive_frame(sk);

    cfg_done = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 11; i++) drive_frame(tbl[i]);

    rst_133 = 1'b0;
    repeat (2) tick();
    chk_reset_vals();
    rst_133 = 1'b1;
    repeat (5) tick();
    drive_frame(tbl[0]);
    drive_frame(tbl[1]);
    drive_frame(tbl[2]);

    chk("words_left", q_exp.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmos_capture_ctrl.md
# cmos_capture_ctrl

Sequences the CMOS camera pixel stream into the write side of the capture FIFO that feeds the SDRAM write scheduler. It runs in the cmos_pclk domain and holds off capture until camera configuration is done. After configuration it discards a programmable number of settling frames, then packs byte pairs into RGB565 words and writes them to the FIFO. It also produces frame/line framing pulses and sticky error status for the SDRAM and VGA sequencing logic.

## Interface
Parameters:
- H_PIXELS, 640, 16-bit words per line (href-high window).
- V_LINES, 480, lines per frame.
- SKIP_FRAMES, 10, frames discarded after cfg_done before first capture (0 allowed).

Ports:
- cmos_pclk  in  1  capture clock; all logic rising-edge.
- rst_133  in  1  reset rst_133, asynchronous, active-low; clock cmos_pclk.
- cfg_done  in  1  camera register config complete; asynchronous (100 MHz domain), 2-FF synchronised internally.
- capture_en  in  1  level enable; sampled only at frame boundaries.
- cmos_vsyn  in  1  camera vsync; rising edge = frame boundary.
- cmos_href  in  1  camera line valid.
- cmos_data  in  8  camera pixel byte, high byte first.
- fifo_full  in  1  capture FIFO full (write side).
- fifo_wrreq  out  1  one-cycle write strobe.
- fifo_data  out  16  {first byte, second byte}.
- frame_start  out  1  one-cycle pulse, first captured frame boundary.
- frame_done  out  1  one-cycle pulse, V_LINES complete lines written.
- line_cnt  out  10  lines completed in current frame.
- overflow  out  1  sticky: word dropped because fifo_full.
- line_err  out  1  sticky: line ended with pixel count ≠ H_PIXELS or odd byte count.
- frame_err  out  1  sticky: vsync rose before V_LINES lines.

## Operation
- Inputs cmos_vsyn/href/data registered once (stage r1). Edges are detected between r1 and r2.
- FSM states:
  - WAIT_CFG: go to SKIP when synchronised cfg_done=1.
  - SKIP: count vsync rising edges. After SKIP_FRAMES edges, go to WAIT_VS. With SKIP_FRAMES=0, go directly.
  - WAIT_VS: on vsync rising edge with capture_en=1, go to ACTIVE. That same edge clears line_cnt, pix_cnt, byte phase and all three sticky flags, and produces frame_start.
  - ACTIVE: pack bytes and count lines. Leave to WAIT_VS when line_cnt reaches V_LINES, producing frame_done. A vsync rise while in ACTIVE with line_cnt < V_LINES sets frame_err and restarts the frame in place: counters cleared, frame_start pulsed if capture_en=1, otherwise go to WAIT_VS.
- Byte packing, ACTIVE only:
  - While href_r1=1, phase toggles each cycle.
  - Phase 0 latches the high byte. Phase 1 forms the word and requests a write.
  - If fifo_full=1 on the request cycle, the word is dropped, overflow is set, and pix_cnt still increments.
- On href falling edge:
  - line_err is set if pix_cnt ≠ H_PIXELS or phase=1. Any partial byte is discarded.
  - phase and pix_cnt clear; line_cnt increments.
- pix_cnt is 11 bits and saturates at 2047. line_cnt saturates at 1023.
- Bytes outside ACTIVE are never written.
- capture_en falling mid-frame does not abort: the frame completes, then the FSM idles in WAIT_VS.
- Reset values: FSM=WAIT_CFG; all outputs 0; fifo_data=0.
- Reset mid-frame: the FIFO is not flushed by this block. After reset, the full SKIP sequence repeats.

## Timing
- Pixel latency: byte pair on pads at edges k (high byte) and k+1 (low byte). fifo_wrreq=1 with the word during the cycle after edge k+2.
- fifo_wrreq is never high two consecutive cycles.
- frame_start is high the cycle after the vsync rising edge is detected, i.e. 2 pclk after the pad edge.
- frame_done is high the cycle after the final href falling edge is detected.
- line_cnt updates in the same cycle as frame_done.
- cfg_done latency: 2 pclk synchroniser plus 1 cycle state transition.
- fifo_full is sampled on the request cycle only, with no lookahead.

## Configuration
- CAPTURE_TEST_PATTERN_EN:
  - Defined: in ACTIVE, fifo_data is replaced by an 8-band colour bar selected by pix_cnt[9:7]. The bands are white, yellow, cyan, green, magenta, red, blue, black in RGB565. Write timing, counts and error flags remain driven by the real href/vsync.
  - Undefined: camera data only, and no pattern logic is synthesised.

## Test plan
- Reset, cfg_done=0, 5 vsync pulses → FSM stays WAIT_CFG, no fifo_wrreq. Raise cfg_done with SKIP_FRAMES=2 → first frame_start on the 3rd vsync rise.
- Full 640×480 frame, data = incrementing bytes → 307200 writes. First word 0x0001, second 0x0203. One frame_done, line_cnt=480, no error flags.
- fifo_full held high for 10 pclk mid-line → 5 words dropped, overflow=1, remaining line words correct, line_err=0. overflow clears at next frame_start.
- One line of 639 words, and one line with odd byte count 1279 → line_err=1, frame_done still pulsed after 480 lines.
- vsync rises after 100 lines → frame_err=1, no frame_done, new frame_start, line_cnt=0.
- capture_en dropped at line 200 → frame completes (frame_done), next vsync produces no frame_start and no writes. With CAPTURE_TEST_PATTERN_EN, word at pix_cnt=0 is 0xFFFF and at pix_cnt=128 is 0xFFE0.
